// File: rtl/sevseg_capture.sv
// Receive-side monitor for a multiplexed seven-segment bus: settles, decodes and frames the scan.
// Optional macro SEVSEG_CAPTURE_DP_EN enables decimal-point capture on the dp output.
module sevseg_capture #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anode,
  input  logic [7:0]  sevseg,
  output logic [15:0] digits,
  output logic [5:0]  num,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        frame_done,
  output logic        err
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef SEVSEG_CAPTURE_DP_EN
  localparam int unsigned SEGW = 8;
`else
  localparam int unsigned SEGW = 7;
`endif

  logic [3:0]      r_an_s1, r_an_s2;
  logic [SEGW-1:0] r_seg_s1, r_seg_s2;
  logic [SW-1:0]   r_settle;
  logic [3:0]      r_mask;
  logic            r_bad;
  logic [15:0]     r_shadow;
  logic [15:0]     r_digits;
  logic [5:0]      r_num;
  logic            r_valid;
  logic            r_fd;
  logic            r_err;
  logic [TW-1:0]   r_to_cnt;

  logic            w_same;
  logic            w_capture;
  logic [2:0]      w_nlow;
  logic [1:0]      w_slot;
  logic            w_single;
  logic            w_multi;
  logic [3:0]      w_nib;
  logic            w_seg_bad;
  logic            w_frame_full;
  logic [3:0]      w_mask_base;
  logic            w_bad_base;
  logic [3:0]      w_v0, w_v1;
  logic [6:0]      w_sum;
  logic            w_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_s1  <= '1;
      r_an_s2  <= '1;
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
    end else begin
      r_an_s1  <= anode;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= sevseg[SEGW-1:0];
      r_seg_s2 <= r_seg_s1;
    end
  end

  // s1 is next cycle's s2, so comparing them resets the counter on the same edge s2 changes
  assign w_same    = ({r_an_s1, r_seg_s1} == {r_an_s2, r_seg_s2});
  assign w_capture = w_same && (r_settle == SW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
    end else if (!w_same) begin
      r_settle <= '0;
    end else if (r_settle != SW'(SETTLE_CYCLES)) begin
      r_settle <= r_settle + SW'(1);
    end
  end

  always_comb begin
    w_nlow = '0;
    w_slot = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!r_an_s2[i]) begin
        w_nlow = w_nlow + 3'd1;
        w_slot = 2'(i);
      end
    end
  end

  assign w_single = (w_nlow == 3'd1);
  assign w_multi  = (w_nlow > 3'd1);

  always_comb begin
    w_seg_bad = 1'b0;
    case (r_seg_s2[6:0])
      7'h40:   w_nib = 4'd0;
      7'h79:   w_nib = 4'd1;
      7'h24:   w_nib = 4'd2;
      7'h30:   w_nib = 4'd3;
      7'h19:   w_nib = 4'd4;
      7'h12:   w_nib = 4'd5;
      7'h02:   w_nib = 4'd6;
      7'h78:   w_nib = 4'd7;
      7'h00:   w_nib = 4'd8;
      7'h10:   w_nib = 4'd9;
      7'h7F:   w_nib = 4'hF;
      default: begin
        w_nib     = 4'hF;
        w_seg_bad = 1'b1;
      end
    endcase
  end

  // A capture coinciding with frame completion starts the next frame from an empty mask
  assign w_frame_full = (r_mask == 4'hF);
  assign w_mask_base  = w_frame_full ? 4'h0 : r_mask;
  assign w_bad_base   = w_frame_full ? 1'b0 : r_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask   <= '0;
      r_bad    <= 1'b0;
      r_shadow <= '1;
    end else begin
      r_mask <= w_mask_base;
      r_bad  <= w_bad_base;
      if (w_capture && w_multi) begin
        r_bad <= 1'b1;
      end else if (w_capture && w_single) begin
        r_shadow[{w_slot, 2'b00} +: 4] <= w_nib;
        r_mask <= w_mask_base | (4'b0001 << w_slot);
        r_bad  <= w_bad_base | w_seg_bad;
      end
    end
  end

  assign w_v0  = (r_shadow[3:0] == 4'hF) ? 4'd0 : r_shadow[3:0];
  assign w_v1  = (r_shadow[7:4] == 4'hF) ? 4'd0 : r_shadow[7:4];
  assign w_sum = 7'(w_v1) * 7'd10 + 7'(w_v0);
  assign w_ovf = (w_sum > 7'd63);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '1;
      r_num    <= '0;
      r_valid  <= 1'b0;
      r_fd     <= 1'b0;
      r_err    <= 1'b0;
      r_to_cnt <= '0;
    end else if (w_frame_full) begin
      r_digits <= r_shadow;
      r_num    <= w_ovf ? 6'd63 : w_sum[5:0];
      r_err    <= r_bad | w_ovf;
      r_fd     <= 1'b1;
      r_valid  <= 1'b1;
      r_to_cnt <= '0;
    end else begin
      r_fd <= 1'b0;
      if (r_to_cnt != TW'(TIMEOUT_CYCLES)) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
      if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SEVSEG_CAPTURE_DP_EN
  logic [3:0] r_shdp;
  logic [3:0] r_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shdp <= '0;
      r_dp   <= '0;
    end else begin
      if (w_capture && w_single) begin
        r_shdp[w_slot] <= ~r_seg_s2[7];
      end
      if (w_frame_full) begin
        r_dp <= r_shdp;
      end
    end
  end

  assign dp = r_dp;
`else
  logic w_unused_dp;
  assign w_unused_dp = sevseg[7];
  assign dp          = '0;
`endif

  assign digits     = r_digits;
  assign num        = r_num;
  assign valid      = r_valid;
  assign frame_done = r_fd;
  assign err        = r_err;

endmodule

// File: tb/tb_sevseg_capture.sv
// Directed bench for sevseg_capture: scans frames onto the bus and checks decoded outputs.
// Expected dp depends on whether SEVSEG_CAPTURE_DP_EN is defined for the build.
module tb_sevseg_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  anode;
  logic [7:0]  sevseg;
  logic [15:0] digits;
  logic [5:0]  num;
  logic [3:0]  dp;
  logic        valid;
  logic        frame_done;
  logic        err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned fd_cnt   = 0;
  int unsigned fd_base;

  sevseg_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .anode      (anode),
    .sevseg     (sevseg),
    .digits     (digits),
    .num        (num),
    .dp         (dp),
    .valid      (valid),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
  end

  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
    anode  = a;
    sevseg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3);
    drive(4'b1110, s0, 10);
    drive(4'b1101, s1, 10);
    drive(4'b1011, s2, 10);
    drive(4'b0111, s3, 10);
    drive(4'b1111, 8'hFF, 4);
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    anode  = 4'hF;
    sevseg = 8'hFF;
    repeat (3) @(negedge clk);
    n_checks++; if (digits !== 16'hFFFF) $display("FAIL reset_digits got %h exp %h", digits, 16'hFFFF); else n_pass++;
    n_checks++; if (num !== 6'd0) $display("FAIL reset_num got %0d exp 0", num); else n_pass++;
    n_checks++; if ({valid, err, frame_done} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {valid, err, frame_done}); else n_pass++;
    n_checks++; if (dp !== 4'b0000) $display("FAIL reset_dp got %b exp 0000", dp); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_display_15;
    fd_base = fd_cnt;
    scan(8'h92, 8'hF9, 8'hFF, 8'hFF);
    n_checks++; if (fd_cnt !== fd_base + 1) $display("FAIL d15_frame_done got %0d exp %0d", fd_cnt - fd_base, 1); else n_pass++;
    n_checks++; if (digits !== 16'hFF15) $display("FAIL d15_digits got %h exp %h", digits, 16'hFF15); else n_pass++;
    n_checks++; if (num !== 6'd15) $display("FAIL d15_num got %0d exp 15", num); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL d15_err got %b exp 0", err); else n_pass++;
    n_checks++; if (valid !== 1'b1) $display("FAIL d15_valid got %b exp 1", valid); else n_pass++;
    n_checks++; if (dp !== 4'b0000) $display("FAIL d15_dp got %b exp 0000", dp); else n_pass++;
  endtask

  task automatic test_display_60_then_3;
    fd_base = fd_cnt;
    scan(8'hC0, 8'h82, 8'hFF, 8'hFF);
    n_checks++; if (fd_cnt !== fd_base + 1) $display("FAIL d60_frame_done got %0d exp 1", fd_cnt - fd_base); else n_pass++;
    n_checks++; if (digits !== 16'hFF60) $display("FAIL d60_digits got %h exp %h", digits, 16'hFF60); else n_pass++;
    n_checks++; if (num !== 6'd60) $display("FAIL d60_num got %0d exp 60", num); else n_pass++;
    fd_base = fd_cnt;
    scan(8'hB0, 8'hFF, 8'hFF, 8'hFF);
    n_checks++; if (fd_cnt !== fd_base + 1) $display("FAIL d3_frame_done got %0d exp 1", fd_cnt - fd_base); else n_pass++;
    n_checks++; if (digits !== 16'hFFF3) $display("FAIL d3_digits got %h exp %h", digits, 16'hFFF3); else n_pass++;
    n_checks++; if (num !== 6'd3) $display("FAIL d3_num got %0d exp 3", num); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL d3_err got %b exp 0", err); else n_pass++;
  endtask

  task automatic test_glitch;
    fd_base = fd_cnt;
    for (int i = 0; i < 10; i++) begin
      drive(4'b1110, 8'hC0, 2);
      drive(4'b1110, 8'hF9, 2);
    end
    drive(4'b1101, 8'hA4, 10);
    drive(4'b1011, 8'hFF, 10);
    drive(4'b0111, 8'hFF, 10);
    drive(4'b1111, 8'hFF, 4);
    n_checks++; if (fd_cnt !== fd_base) $display("FAIL glitch_no_frame got %0d pulses exp 0", fd_cnt - fd_base); else n_pass++;
    n_checks++; if (digits !== 16'hFFF3) $display("FAIL glitch_digits_held got %h exp %h", digits, 16'hFFF3); else n_pass++;
    drive(4'b1110, 8'h99, 10);
    drive(4'b1111, 8'hFF, 4);
    n_checks++; if (fd_cnt !== fd_base + 1) $display("FAIL glitch_complete got %0d pulses exp 1", fd_cnt - fd_base); else n_pass++;
    n_checks++; if (digits !== 16'hFF24) $display("FAIL glitch_digits got %h exp %h", digits, 16'hFF24); else n_pass++;
    n_checks++; if (num !== 6'd24) $display("FAIL glitch_num got %0d exp 24", num); else n_pass++;
  endtask

  task automatic test_bad_inputs;
    drive(4'b1100, 8'hC0, 10);
    scan(8'h99, 8'hA4, 8'hFF, 8'hFF);
    n_checks++; if (err !== 1'b1) $display("FAIL bad_anode_err got %b exp 1", err); else n_pass++;
    n_checks++; if (digits !== 16'hFF24) $display("FAIL bad_anode_digits got %h exp %h", digits, 16'hFF24); else n_pass++;
    scan(8'hD5, 8'h99, 8'hFF, 8'hFF);
    n_checks++; if (err !== 1'b1) $display("FAIL bad_seg_err got %b exp 1", err); else n_pass++;
    n_checks++; if (digits !== 16'hFF4F) $display("FAIL bad_seg_digits got %h exp %h", digits, 16'hFF4F); else n_pass++;
    n_checks++; if (num !== 6'd40) $display("FAIL bad_seg_num got %0d exp 40", num); else n_pass++;
    scan(8'hC0, 8'hF9, 8'hFF, 8'hFF);
    n_checks++; if (err !== 1'b0) $display("FAIL bad_clear_err got %b exp 0", err); else n_pass++;
    n_checks++; if (num !== 6'd10) $display("FAIL bad_clear_num got %0d exp 10", num); else n_pass++;
  endtask

  task automatic test_overflow;
    scan(8'h90, 8'h90, 8'hFF, 8'hFF);
    n_checks++; if (digits !== 16'hFF99) $display("FAIL ovf_digits got %h exp %h", digits, 16'hFF99); else n_pass++;
    n_checks++; if (num !== 6'd63) $display("FAIL ovf_num got %0d exp 63", num); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL ovf_err got %b exp 1", err); else n_pass++;
  endtask

  task automatic test_dp;
    logic [3:0] exp_dp;
`ifdef SEVSEG_CAPTURE_DP_EN
    exp_dp = 4'b0010;
`else
    exp_dp = 4'b0000;
`endif
    scan(8'hC0, 8'h79, 8'hFF, 8'hFF);
    n_checks++; if (dp !== exp_dp) $display("FAIL dp_capture got %b exp %b", dp, exp_dp); else n_pass++;
    n_checks++; if (digits !== 16'hFF10) $display("FAIL dp_digits got %h exp %h", digits, 16'hFF10); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL dp_err got %b exp 0", err); else n_pass++;
  endtask

  task automatic test_timeout;
    drive(4'b1111, 8'hFF, 500);
    n_checks++; if (valid !== 1'b1) $display("FAIL timeout_early_valid got %b exp 1", valid); else n_pass++;
    drive(4'b1111, 8'hFF, 600);
    n_checks++; if (valid !== 1'b0) $display("FAIL timeout_valid got %b exp 0", valid); else n_pass++;
    n_checks++; if (digits !== 16'hFF10) $display("FAIL timeout_digits got %h exp %h", digits, 16'hFF10); else n_pass++;
    n_checks++; if (num !== 6'd10) $display("FAIL timeout_num got %0d exp 10", num); else n_pass++;
  endtask

  task automatic test_mid_reset;
    drive(4'b1110, 8'h99, 5);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (digits !== 16'hFFFF) $display("FAIL midrst_digits got %h exp %h", digits, 16'hFFFF); else n_pass++;
    n_checks++; if (num !== 6'd0) $display("FAIL midrst_num got %0d exp 0", num); else n_pass++;
    n_checks++; if ({valid, err} !== 2'b00) $display("FAIL midrst_flags got %b exp 00", {valid, err}); else n_pass++;
    @(negedge clk);
    rst_n   = 1'b1;
    fd_base = fd_cnt;
    drive(4'b1101, 8'hA4, 10);
    drive(4'b1011, 8'hFF, 10);
    drive(4'b0111, 8'hFF, 10);
    drive(4'b1111, 8'hFF, 4);
    n_checks++; if (fd_cnt !== fd_base) $display("FAIL midrst_partial_discard got %0d pulses exp 0", fd_cnt - fd_base); else n_pass++;
    drive(4'b1110, 8'h99, 10);
    drive(4'b1111, 8'hFF, 4);
    n_checks++; if (digits !== 16'hFF24) $display("FAIL midrst_recover_digits got %h exp %h", digits, 16'hFF24); else n_pass++;
    n_checks++; if (valid !== 1'b1) $display("FAIL midrst_recover_valid got %b exp 1", valid); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_display_15;
    test_display_60_then_3;
    test_glitch;
    test_bad_inputs;
    test_overflow;
    test_dp;
    test_timeout;
    test_mid_reset;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
